// File: rtl/cache_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_mem_arbiter_if : I-cache / D-cache / physical-memory line bus  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  // slave: the arbiter itself; master: the caches and memory around it
  modport slave (
    input  i_read, i_addr,
    output i_rdata, i_resp,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_addr, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_read, i_addr,
    input  i_rdata, i_resp,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_mem_arbiter : shares one memory line port between I$ and D$.   |
// | Optional macro ARB_RR_EN: round-robin on simultaneous requests.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic                clk,
  input  logic                reset,
  cache_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic GRANT_I  = 1'b0;
  localparam logic GRANT_D  = 1'b1;
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [LINE_W-1:0] wdata_q, wdata_nx;
  logic              op_q, op_nx;
  logic              last_grant, last_grant_nx;

  logic              d_req, i_req, pick_d;
  logic              pmem_read_c, pmem_write_c, i_resp_c, d_resp_c;

  assign d_req = bus.d_read | bus.d_write;
  assign i_req = bus.i_read;

`ifdef ARB_RR_EN
  // On a tie, favour whoever was not served last
  assign pick_d = d_req & (~i_req | (last_grant == GRANT_I));
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_q       <= OP_READ;
      last_grant <= GRANT_I;
    end else begin
      state      <= state_nx;
      addr_q     <= addr_nx;
      wdata_q    <= wdata_nx;
      op_q       <= op_nx;
      last_grant <= last_grant_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    addr_nx       = addr_q;
    wdata_nx      = wdata_q;
    op_nx         = op_q;
    last_grant_nx = last_grant;
    pmem_read_c   = 1'b0;
    pmem_write_c  = 1'b0;
    i_resp_c      = 1'b0;
    d_resp_c      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_d) begin
          state_nx = SERVE_D;
          addr_nx  = bus.d_addr;
          wdata_nx = bus.d_wdata;
          op_nx    = bus.d_write ? OP_WRITE : OP_READ;
        end else if (i_req) begin
          state_nx = SERVE_I;
          addr_nx  = bus.i_addr;
          op_nx    = OP_READ;
        end
      end
      SERVE_I, SERVE_D: begin
        pmem_read_c  = (op_q == OP_READ);
        pmem_write_c = (op_q == OP_WRITE);
        // Completion always passes through IDLE so a just-served requester
        // has a cycle to drop its request before arbitration resumes.
        if (bus.pmem_resp) begin
          state_nx      = IDLE;
          last_grant_nx = (state == SERVE_D) ? GRANT_D : GRANT_I;
          i_resp_c      = (state == SERVE_I) & reset;
          d_resp_c      = (state == SERVE_D) & reset;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.pmem_read  = pmem_read_c;
  assign bus.pmem_write = pmem_write_c;
  assign bus.pmem_addr  = addr_q;
  assign bus.pmem_wdata = wdata_q;
  assign bus.i_resp     = i_resp_c;
  assign bus.d_resp     = d_resp_c;
  assign bus.i_rdata    = i_resp_c ? bus.pmem_rdata : '0;
  assign bus.d_rdata    = d_resp_c ? bus.pmem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cache_mem_arbiter : random traffic vs. transaction-level model.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_cache_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int NCYC   = 4000;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [LINE_W-1:0] obs,
                           input logic [LINE_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    v = '0;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [ADDR_W-1:0] a;
    a = $urandom;
    return {a[ADDR_W-1:5], 5'b0};
  endfunction

  // Requester agents
  bit                i_want, i_busy, i_done;
  int                i_cool;
  logic [ADDR_W-1:0] i_a;
  bit                d_want, d_busy, d_done;
  int                d_cool, d_op;        // 0 read, 1 write, 2 read+write
  logic [ADDR_W-1:0] d_a;
  logic [LINE_W-1:0] d_w;

  // Transaction-level model of the memory port
  bit                m_active, m_who, m_write, m_last;   // who/last: 0=I 1=D
  int                m_lat;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata, m_rdata;
  bit                mem_resp, exp_i, exp_d, dq, iq, take_d;

  initial begin
    reset  = 1'b0;
    i_want = 1; i_busy = 1; i_done = 0; i_cool = 0; i_a = rand_addr();
    d_want = 1; d_busy = 1; d_done = 0; d_cool = 0; d_op = 1;
    d_a    = rand_addr(); d_w = rand_line();
    m_active = 0; m_last = 0; m_who = 0; m_write = 0; m_lat = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
    bus.i_read = 1'b1; bus.i_addr = i_a;
    bus.d_read = 1'b0; bus.d_write = 1'b1; bus.d_addr = d_a; bus.d_wdata = d_w;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    @(posedge clk);

    for (int cyc = 1; cyc < NCYC; cyc++) begin
      @(negedge clk);
      // I-cache agent: drop request the cycle after its response
      if (i_done) begin
        i_want = 0; i_busy = 0; i_done = 0; i_cool = $urandom_range(0, 3);
      end else if (!i_busy) begin
        if (i_cool > 0) i_cool--;
        else if ($urandom_range(0, 1) == 1) begin
          i_want = 1; i_busy = 1; i_a = rand_addr();
        end
      end else if (m_active && !m_who && $urandom_range(0, 15) == 0) i_want = 0;
      // D-cache agent
      if (d_done) begin
        d_want = 0; d_busy = 0; d_done = 0; d_cool = $urandom_range(0, 3);
      end else if (!d_busy) begin
        if (d_cool > 0) d_cool--;
        else if ($urandom_range(0, 1) == 1) begin
          d_want = 1; d_busy = 1; d_op = $urandom_range(0, 2);
          d_a = rand_addr(); d_w = rand_line();
        end
      end else if (m_active && m_who && $urandom_range(0, 15) == 0) d_want = 0;
      // Inputs wander while held; only the grant-cycle values may stick
      if ($urandom_range(0, 7) == 0) begin d_a = rand_addr(); d_w = rand_line(); end
      if ($urandom_range(0, 7) == 0) i_a = rand_addr();

      if (cyc < 3) reset = 1'b0;
      else         reset = !(m_active && $urandom_range(0, 63) == 0);

      if (!reset)             mem_resp = 0;
      else if (m_active)      mem_resp = (m_lat == 1);
      else                    mem_resp = ($urandom_range(0, 7) == 0);

      bus.i_read     = i_want;
      bus.i_addr     = i_a;
      bus.d_read     = d_want && (d_op != 1);
      bus.d_write    = d_want && (d_op != 0);
      bus.d_addr     = d_a;
      bus.d_wdata    = d_w;
      bus.pmem_resp  = mem_resp;
      bus.pmem_rdata = m_active ? m_rdata : rand_line();

      #1;
      exp_i = m_active && !m_who && mem_resp;
      exp_d = m_active &&  m_who && mem_resp;
      check_val("pmem_read",  LINE_W'(bus.pmem_read),  LINE_W'(m_active && !m_write));
      check_val("pmem_write", LINE_W'(bus.pmem_write), LINE_W'(m_active &&  m_write));
      if (m_active) begin
        check_val("pmem_addr",  LINE_W'(bus.pmem_addr), LINE_W'(m_addr));
        check_val("pmem_wdata", bus.pmem_wdata, m_wdata);
      end
      check_val("i_resp",  LINE_W'(bus.i_resp), LINE_W'(exp_i));
      check_val("d_resp",  LINE_W'(bus.d_resp), LINE_W'(exp_d));
      check_val("i_rdata", bus.i_rdata, exp_i ? m_rdata : '0);
      check_val("d_rdata", bus.d_rdata, exp_d ? m_rdata : '0);

      // Advance the model across the coming rising edge
      if (!reset) begin
        m_active = 0; m_last = 0; m_wdata = '0;
        if (!i_want) i_busy = 0;
        if (!d_want) d_busy = 0;
      end else if (m_active) begin
        if (mem_resp) begin
          m_active = 0; m_last = m_who;
          if (m_who) d_done = 1; else i_done = 1;
        end else m_lat--;
      end else begin
        dq = bus.d_read || bus.d_write;
        iq = bus.i_read;
`ifdef ARB_RR_EN
        take_d = dq && (!iq || !m_last);
`else
        take_d = dq;
`endif
        if (take_d) begin
          m_active = 1; m_who = 1; m_write = bus.d_write;
          m_addr = bus.d_addr; m_wdata = bus.d_wdata;
        end else if (iq) begin
          m_active = 1; m_who = 0; m_write = 0; m_addr = bus.i_addr;
        end
        if (m_active) begin
          m_lat = $urandom_range(1, 5); m_rdata = rand_line();
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
Shares the single physical-memory line port between the I-cache (fed by the IF stage's instruction fetch path) and the D-cache (MEM stage).
- Grants one requester at a time.
- Latches that requester's address and write data, forwards the transaction to physical memory, and routes the response back.
- Sits between the two caches and the memory model/L2 at top level.

Parameters:
ADDR_W, 32, byte address width of line requests
LINE_W, 256, cache line width in bits

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
i_read  in  1  I-cache line read request, held until i_resp
i_addr  in  ADDR_W  I-cache line address
i_rdata  out  LINE_W  line returned to I-cache
i_resp  out  1  one-cycle completion pulse to I-cache
d_read  in  1  D-cache line read request, held until d_resp
d_write  in  1  D-cache line write-back request, held until d_resp
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache write-back line
d_rdata  out  LINE_W  line returned to D-cache
d_resp  out  1  one-cycle completion pulse to D-cache
pmem_read  out  1  memory read command
pmem_write  out  1  memory write command
pmem_addr  out  ADDR_W  memory address (latched)
pmem_wdata  out  LINE_W  memory write line (latched)
pmem_rdata  in  LINE_W  memory read line
pmem_resp  in  1  memory completion pulse

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE; last_grant=I.
  - pmem_read, pmem_write, i_resp and d_resp are 0.
  - Address and data latches clear to 0.
  - i_rdata and d_rdata read 0 whenever their resp is 0.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - pmem_read=pmem_write=0.
  - If d_read|d_write: go to SERVE_D, latch d_addr into addr_q, d_wdata into wdata_q, and the operation (write if d_write, else read) into op_q.
  - Else if i_read: go to SERVE_I, latch i_addr, op_q=read.
  - Else stay in IDLE.
  - Default priority: D over I.
- SERVE_x:
  - Assert pmem_read (op_q=read) or pmem_write (op_q=write).
  - pmem_addr=addr_q; pmem_wdata=wdata_q.
  - Commands stay asserted until pmem_resp.
- On pmem_resp in SERVE_x:
  - Same cycle: x_resp=1 and x_rdata=pmem_rdata (combinational pass-through).
  - Next state is IDLE; last_grant<=x.
  - The non-granted resp stays 0.
- Mandatory IDLE turnaround cycle after every completion. A requester drops its request the cycle after resp, so the turnaround prevents a stale re-grant.
- Latency:
  - Request seen in IDLE at edge t; pmem command asserted from cycle t+1.
  - Minimum 2 cycles from request to resp for a 1-cycle memory.
- d_read and d_write both high: treated as a write; a single transaction is issued.
- Request dropped mid-transaction: ignored; the transaction completes and resp still pulses.
- pmem_resp while in IDLE: ignored; no resp to either requester.
- Reset mid-transaction: returns to IDLE and drops pmem_read/pmem_write the next cycle; the outstanding memory response is discarded.
- Output constraints: pmem_read and pmem_write are never both 1; i_resp and d_resp are never both 1.

Optional Feature:
Macro ARB_RR_EN.
- Defined: on a simultaneous I and D request in IDLE, the grant goes to the requester that is not last_grant (round-robin). With a lone request, that requester is granted immediately.
- Undefined: fixed D-over-I priority; last_grant is still tracked but unused for arbitration.

Test Plan:
- Reset held low 3 cycles with i_read=1 and d_write=1 → all outputs 0, no pmem command. After release, first grant goes to D (pmem_write=1, pmem_addr=d_addr).
- i_read=1, i_addr=0x0000_0060; pmem_resp after 4 cycles with pmem_rdata=pattern A → pmem_read high exactly 4 cycles; i_resp pulses 1 cycle with i_rdata=A; d_resp stays 0.
- d_write=1, d_addr=0x0000_1000, d_wdata=B; d_addr changed mid-transaction → pmem_addr stays 0x0000_1000 and pmem_wdata=B throughout; d_resp pulses once.
- i_read and d_read asserted together, each held until resp →
  - Without ARB_RR_EN: D served, then IDLE cycle, then I served.
  - With ARB_RR_EN after a prior D grant: I served first.
- pmem_resp pulsed while in IDLE → no i_resp/d_resp, state remains IDLE.
- reset driven low during SERVE_D before pmem_resp → pmem_write 0 next cycle, d_resp never asserted, state IDLE.
